// File: rtl/bus_dest_decoder.sv
// bus_dest_decoder: queues {dest_sel, bus_in} transfer requests and issues them
// as one-hot destination load enables, one per unstalled cycle.
// Optional build macro R0_ZERO_EN: code 0 becomes a null destination that is
// queued and popped but never asserts a load enable or counts as a transfer.
module bus_dest_decoder #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] bus_in,
    input  logic [4:0]  dest_sel,
    input  logic        dest_valid,
    output logic        dest_ready,
    input  logic        dest_stall,
    output logic [23:0] load_en,
    output logic [31:0] load_data,
    output logic        err_bad_sel,
    output logic [15:0] xfer_count,
    output logic [3:0]  fifo_level
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef R0_ZERO_EN
    localparam bit R0_NULL = 1'b1;
`else
    localparam bit R0_NULL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [4:0]    sel_mem  [FIFO_DEPTH];
    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          push, pop, bad, head_null;
    logic [4:0]    head_sel;
    logic [31:0]   head_data;

    assign dest_ready = fifo_level != 4'(FIFO_DEPTH);

    // Request qualification, head decode and next state; a full queue refuses
    // pushes even when a pop happens at the same edge because ready is registered.
    always_comb begin
        push       = dest_valid && dest_ready && (dest_sel <= 5'd23);
        bad        = dest_valid && dest_ready && (dest_sel > 5'd23);
        pop        = (fifo_level != 4'd0) && !dest_stall;
        head_sel   = sel_mem[rd_ptr];
        head_data  = data_mem[rd_ptr];
        head_null  = R0_NULL && (head_sel == 5'd0);
        state_next = pop ? ISSUE : ((fifo_level != 4'd0) ? HOLD : IDLE);
    end

    // Queue storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            sel_mem[wr_ptr]  <= dest_sel;
            data_mem[wr_ptr] <= bus_in;
        end
    end

    // Pointers, occupancy, issued load, sticky error, transfer count and state.
    always_ff @(posedge clock) begin
        if (clear) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_level  <= 4'd0;
            load_en     <= 24'd0;
            load_data   <= 32'd0;
            err_bad_sel <= 1'b0;
            xfer_count  <= 16'd0;
            state       <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_level <= fifo_level + 4'(push) - 4'(pop);
            load_en    <= (pop && !head_null) ? (24'd1 << head_sel) : 24'd0;
            if (pop) load_data <= head_data;
            if (pop && !head_null) xfer_count <= xfer_count + 16'd1;
            if (bad) err_bad_sel <= 1'b1;
            state <= state_next;
        end
    end
endmodule
